// File: rtl/raster_line_engine_if.sv
// rtl/raster_line_engine_if.sv - beam position, endpoint and pixel-out bundle of the line engine
interface raster_line_engine_if #(
    parameter int H_BITS = 11,
    parameter int V_BITS = 10
);
    logic [H_BITS-1:0] hcount_in;
    logic [V_BITS-1:0] vcount_in;
    logic              new_frame_in;
    logic [H_BITS-1:0] x1_in;
    logic [H_BITS-1:0] x2_in;
    logic [V_BITS-1:0] y1_in;
    logic [V_BITS-1:0] y2_in;
    logic              line_active;
    logic [23:0]       color_out;
    logic              busy_out;
    logic              overrun_out;

    modport master (
        output hcount_in, vcount_in, new_frame_in,
        output x1_in, x2_in, y1_in, y2_in, line_active,
        input  color_out, busy_out, overrun_out
    );

    modport slave (
        input  hcount_in, vcount_in, new_frame_in,
        input  x1_in, x2_in, y1_in, y2_in, line_active,
        output color_out, busy_out, overrun_out
    );
endinterface

// File: rtl/raster_line_engine.sv
// rtl/raster_line_engine.sv - all-octant Bresenham line sprite building per-row spans a row ahead of the beam
module raster_line_engine #(
    parameter int          H_BITS = 11,
    parameter int          V_BITS = 10,
    parameter logic [23:0] COLOR  = 24'hFF_FF_FF,
    parameter int          THICK  = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    raster_line_engine_if.slave  bus
);
    localparam int EW  = H_BITS + 2;
    localparam int E2W = H_BITS + 3;
    localparam logic [H_BITS-1:0] X_ONE = H_BITS'(1);
    localparam logic [V_BITS-1:0] Y_ONE = V_BITS'(1);
    localparam logic [H_BITS:0]   TK    = (H_BITS+1)'(THICK);

    typedef enum logic [1:0] {IDLE, STEP, HOLD, DONE} state_t;

    state_t                state;
    logic [H_BITS-1:0]     x, xb, span_min, span_max;
    logic [V_BITS-1:0]     y, yb;
    logic signed [EW-1:0]  err, dx, dy;
    logic                  x_dec;
    logic                  pending_valid, pending_last;
    logic [V_BITS-1:0]     pending_row;
    logic [H_BITS-1:0]     pending_min, pending_max;
    logic                  active_valid;
    logic [V_BITS-1:0]     active_row;
    logic [H_BITS-1:0]     active_min, active_max;
    logic                  busy_q, overrun_q;
    logic [23:0]           color_q;

    // Endpoint ordering so the walk always runs top to bottom
    logic                  swap;
    logic [H_BITS-1:0]     xa_n, xb_n, adx;
    logic [V_BITS-1:0]     ya_n, yb_n, ady;
    logic signed [EW-1:0]  dx_n, dy_n;

    assign swap = bus.y1_in > bus.y2_in;
    assign xa_n = swap ? bus.x2_in : bus.x1_in;
    assign xb_n = swap ? bus.x1_in : bus.x2_in;
    assign ya_n = swap ? bus.y2_in : bus.y1_in;
    assign yb_n = swap ? bus.y1_in : bus.y2_in;
    assign adx  = (xb_n >= xa_n) ? xb_n - xa_n : xa_n - xb_n;
    assign ady  = yb_n - ya_n;
    assign dx_n = $signed({{(EW-H_BITS){1'b0}}, adx});
    assign dy_n = -$signed({{(EW-V_BITS){1'b0}}, ady});

    // One Bresenham step from the current point
    logic signed [E2W-1:0] e2, dx_e, dy_e;
    logic                  step_x, step_y, at_end;
    logic signed [EW-1:0]  err_n;
    logic [H_BITS-1:0]     x_n, f_min, f_max;
    logic [V_BITS-1:0]     y_n;

    assign e2     = {err, 1'b0};
    assign dx_e   = {dx[EW-1], dx};
    assign dy_e   = {dy[EW-1], dy};
    assign step_x = e2 >= dy_e;
    assign step_y = e2 <= dx_e;
    assign at_end = (x == xb) && (y == yb);
    assign x_n    = step_x ? (x_dec ? x - X_ONE : x + X_ONE) : x;
    assign y_n    = step_y ? y + Y_ONE : y;
    assign f_min  = (x < span_min) ? x : span_min;
    assign f_max  = (x > span_max) ? x : span_max;

    // Error term accumulates both axis contributions when both step
    always_comb begin
        err_n = err;
        if (step_x) err_n = err_n + dy;
        if (step_y) err_n = err_n + dx;
    end

    // Handoff of the pending span at the start of its row, or drop if the row is gone
    logic line_start, transfer, discard;
    assign line_start = (bus.hcount_in == '0);
    assign transfer   = (state == HOLD) && pending_valid && line_start && (bus.vcount_in == pending_row);
    assign discard    = (state == HOLD) && pending_valid && line_start && (bus.vcount_in > pending_row);

    // A span handed off this cycle must already cover column 0 of its row
    logic                  eff_valid;
    logic [V_BITS-1:0]     eff_row;
    logic [H_BITS-1:0]     eff_min, eff_max, lo, hi;
    logic [H_BITS:0]       lo_w, hi_w;
    logic                  hit;

    assign eff_valid = transfer ? 1'b1        : active_valid;
    assign eff_row   = transfer ? pending_row : active_row;
    assign eff_min   = transfer ? pending_min : active_min;
    assign eff_max   = transfer ? pending_max : active_max;
    assign lo_w      = {1'b0, eff_min} - TK;
    assign hi_w      = {1'b0, eff_max} + TK;
    assign lo        = lo_w[H_BITS] ? '0 : lo_w[H_BITS-1:0];
    assign hi        = hi_w[H_BITS] ? '1 : hi_w[H_BITS-1:0];
    assign hit       = eff_valid && (bus.vcount_in == eff_row) && (bus.hcount_in >= lo)
                       && (bus.hcount_in <= hi) && bus.line_active && !bus.new_frame_in;

    // Walk FSM: endpoint latch, stepping, span handoff and status flags
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            xb            <= '0;
            yb            <= '0;
            err           <= '0;
            dx            <= '0;
            dy            <= '0;
            x_dec         <= 1'b0;
            span_min      <= '0;
            span_max      <= '0;
            pending_valid <= 1'b0;
            pending_last  <= 1'b0;
            pending_row   <= '0;
            pending_min   <= '0;
            pending_max   <= '0;
            active_valid  <= 1'b0;
            active_row    <= '0;
            active_min    <= '0;
            active_max    <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else if (bus.new_frame_in) begin
            xb            <= xb_n;
            yb            <= yb_n;
            dx            <= dx_n;
            dy            <= dy_n;
            err           <= dx_n + dy_n;
            x_dec         <= xb_n < xa_n;
            x             <= xa_n;
            y             <= ya_n;
            span_min      <= xa_n;
            span_max      <= xa_n;
            pending_valid <= 1'b0;
            active_valid  <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b1;
            state         <= STEP;
        end else begin
            if (line_start && active_valid && (bus.vcount_in != active_row))
                active_valid <= 1'b0;
            case (state)
                IDLE: ;
                STEP: begin
                    if (line_start && (bus.vcount_in == y))
                        overrun_q <= 1'b1;
                    if (at_end) begin
                        pending_row   <= y;
                        pending_min   <= f_min;
                        pending_max   <= f_max;
                        pending_last  <= 1'b1;
                        pending_valid <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        err <= err_n;
                        x   <= x_n;
                        y   <= y_n;
                        if (step_y) begin
                            pending_row   <= y;
                            pending_min   <= f_min;
                            pending_max   <= f_max;
                            pending_last  <= 1'b0;
                            pending_valid <= 1'b1;
                            span_min      <= x_n;
                            span_max      <= x_n;
                            state         <= HOLD;
                        end else begin
                            span_min <= f_min;
                            span_max <= f_max;
                        end
                    end
                end
                HOLD: begin
                    if (transfer || discard) begin
                        if (transfer) begin
                            active_valid <= 1'b1;
                            active_row   <= pending_row;
                            active_min   <= pending_min;
                            active_max   <= pending_max;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                        pending_valid <= 1'b0;
                        if (pending_last) begin
                            busy_q <= 1'b0;
                            state  <= DONE;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

    // Registered pixel colour, one clock behind the beam position
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) color_q <= '0;
        else           color_q <= hit ? COLOR : 24'h0;
    end

    assign bus.color_out   = color_q;
    assign bus.busy_out    = busy_q;
    assign bus.overrun_out = overrun_q;
endmodule

// File: tb/tb_raster_line_engine.sv
// tb/tb_raster_line_engine.sv - directed raster-scan bench for raster_line_engine
module tb_raster_line_engine;
    localparam int          H_TOT = 128;
    localparam int          V_TOT = 24;
    localparam logic [23:0] COL   = 24'hFF_FF_FF;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hc    = '0;
    logic [9:0]  vc    = '0;
    logic        nf    = 1'b0;
    logic [10:0] x1    = '0;
    logic [10:0] x2    = '0;
    logic [9:0]  y1    = '0;
    logic [9:0]  y2    = '0;
    logic        la    = 1'b1;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic lit0 [V_TOT][H_TOT];
    logic lit2 [V_TOT][H_TOT];
    logic exp0 [V_TOT][H_TOT];
    logic exp2 [V_TOT][H_TOT];
    int   odd_vals;
    int   fall_h, fall_v;
    logic busy_prev, busy_seen;

    always #5 clk = ~clk;

    raster_line_engine_if bus0 ();
    raster_line_engine_if bus2 ();

    assign bus0.hcount_in = hc;  assign bus2.hcount_in = hc;
    assign bus0.vcount_in = vc;  assign bus2.vcount_in = vc;
    assign bus0.new_frame_in = nf; assign bus2.new_frame_in = nf;
    assign bus0.x1_in = x1;      assign bus2.x1_in = x1;
    assign bus0.x2_in = x2;      assign bus2.x2_in = x2;
    assign bus0.y1_in = y1;      assign bus2.y1_in = y1;
    assign bus0.y2_in = y2;      assign bus2.y2_in = y2;
    assign bus0.line_active = la; assign bus2.line_active = la;

    raster_line_engine #(.THICK(0)) dut0 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus0));
    raster_line_engine #(.THICK(2)) dut2 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus2));

    task automatic px(input int h, input int v);
        hc = h[10:0];
        vc = v[9:0];
        @(posedge clk);
        #1;
        if (h < H_TOT && v < V_TOT) begin
            lit0[v][h] = (bus0.color_out != 24'h0);
            lit2[v][h] = (bus2.color_out != 24'h0);
        end
        if (bus0.color_out !== 24'h0 && bus0.color_out !== COL) odd_vals++;
        if (bus2.color_out !== 24'h0 && bus2.color_out !== COL) odd_vals++;
        if (bus0.busy_out === 1'b1) busy_seen = 1'b1;
        if (busy_prev === 1'b1 && bus0.busy_out === 1'b0 && fall_v < 0) begin
            fall_h = h;
            fall_v = v;
        end
        busy_prev = bus0.busy_out;
    endtask

    task automatic nf_px(input int h, input int v);
        nf = 1'b1;
        px(h, v);
        nf = 1'b0;
    endtask

    task automatic scan(input int h0, input int v0, input int v1);
        for (int v = v0; v <= v1; v++)
            for (int h = (v == v0) ? h0 : 0; h < H_TOT; h++)
                px(h, v);
    endtask

    task automatic set_line(input int ax, input int ay, input int bx, input int by);
        x1 = ax[10:0]; y1 = ay[9:0];
        x2 = bx[10:0]; y2 = by[9:0];
    endtask

    task automatic clear_map();
        for (int v = 0; v < V_TOT; v++)
            for (int h = 0; h < H_TOT; h++) begin
                lit0[v][h] = 1'b0; lit2[v][h] = 1'b0;
                exp0[v][h] = 1'b0; exp2[v][h] = 1'b0;
            end
        odd_vals  = 0;
        fall_h    = -1;
        fall_v    = -1;
        busy_seen = 1'b0;
        busy_prev = bus0.busy_out;
    endtask

    function automatic int diff_maps(input bit sel2);
        int d = 0;
        for (int v = 0; v < V_TOT; v++)
            for (int h = 0; h < H_TOT; h++)
                if ((sel2 ? lit2[v][h] : lit0[v][h]) !== (sel2 ? exp2[v][h] : exp0[v][h])) d++;
        return d;
    endfunction

    task automatic test_reset();
        int d;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus0.color_out !== 24'h0) begin n_bad++; $display("FAIL reset_color: got %h required 000000", bus0.color_out); end
        n_cmp++; if (bus0.busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", bus0.busy_out); end
        n_cmp++; if (bus0.overrun_out !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b required 0", bus0.overrun_out); end
        rst_n = 1'b1;
        clear_map();
        scan(0, 0, V_TOT-1);
        d = diff_maps(0) + diff_maps(1);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL reset_no_draw: %0d lit pixels required 0", d); end
        n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b required 0", busy_seen); end
    endtask

    task automatic test_horizontal(input logic active);
        int d;
        clear_map();
        set_line(10, 5, 20, 5);
        la = active;
        if (active) begin
            for (int h = 10; h <= 20; h++) exp0[5][h] = 1'b1;
            for (int h = 8; h <= 22; h++)  exp2[5][h] = 1'b1;
        end
        nf_px(0, 0);
        n_cmp++; if (bus0.busy_out !== 1'b1) begin n_bad++; $display("FAIL horiz_busy_start la=%b: got %b required 1", active, bus0.busy_out); end
        scan(1, 0, V_TOT-1);
        d = diff_maps(0);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL horiz_pixels la=%b: %0d wrong pixels required 0", active, d); end
        d = diff_maps(1);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL horiz_pixels_thick la=%b: %0d wrong pixels required 0", active, d); end
        n_cmp++; if (fall_v !== 5 || fall_h !== 0) begin n_bad++; $display("FAIL horiz_busy_fall la=%b: got row %0d col %0d required row 5 col 0", active, fall_v, fall_h); end
        n_cmp++; if (bus0.overrun_out !== 1'b0) begin n_bad++; $display("FAIL horiz_overrun la=%b: got %b required 0", active, bus0.overrun_out); end
        n_cmp++; if (odd_vals !== 0) begin n_bad++; $display("FAIL horiz_color_value la=%b: %0d odd colours required 0", active, odd_vals); end
        la = 1'b1;
    endtask

    task automatic test_steep();
        int tab [11] = '{100, 100, 101, 101, 101, 102, 102, 102, 102, 103, 103};
        int d;
        for (int sw = 0; sw < 2; sw++) begin
            clear_map();
            if (sw == 0) set_line(100, 10, 103, 20);
            else         set_line(103, 20, 100, 10);
            for (int i = 0; i < 11; i++) begin
                exp0[10+i][tab[i]] = 1'b1;
                for (int k = -2; k <= 2; k++) exp2[10+i][tab[i]+k] = 1'b1;
            end
            nf_px(0, 0);
            scan(1, 0, V_TOT-1);
            d = diff_maps(0);
            n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL steep_pixels swap=%0d: %0d wrong pixels required 0", sw, d); end
            d = diff_maps(1);
            n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL steep_pixels_thick swap=%0d: %0d wrong pixels required 0", sw, d); end
            n_cmp++; if (fall_v !== 20 || fall_h !== 0) begin n_bad++; $display("FAIL steep_busy_fall swap=%0d: got row %0d col %0d required row 20 col 0", sw, fall_v, fall_h); end
            n_cmp++; if (bus0.overrun_out !== 1'b0) begin n_bad++; $display("FAIL steep_overrun swap=%0d: got %b required 0", sw, bus0.overrun_out); end
        end
    endtask

    task automatic test_thick_clamp();
        int d;
        logic [7:0] hi0, hi2;
        clear_map();
        set_line(0, 0, 0, 0);
        exp0[0][0] = 1'b1;
        for (int h = 0; h <= 2; h++) exp2[0][h] = 1'b1;
        nf_px(H_TOT-3, V_TOT-1);
        px(H_TOT-2, V_TOT-1);
        px(H_TOT-1, V_TOT-1);
        scan(0, 0, V_TOT-1);
        d = diff_maps(0);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL point_pixels: %0d wrong pixels required 0", d); end
        d = diff_maps(1);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL point_low_clamp: %0d wrong pixels required 0", d); end
        n_cmp++; if (fall_v !== 0 || fall_h !== 0) begin n_bad++; $display("FAIL point_busy_fall: got row %0d col %0d required row 0 col 0", fall_v, fall_h); end

        clear_map();
        set_line(2046, 7, 2046, 7);
        nf_px(0, 0);
        scan(1, 0, 6);
        px(0, 7);
        for (int h = 2040; h <= 2047; h++) begin
            px(h, 7);
            hi0[h-2040] = (bus0.color_out != 24'h0);
            hi2[h-2040] = (bus2.color_out != 24'h0);
        end
        scan(0, 8, V_TOT-1);
        n_cmp++; if (hi2 !== 8'hF0) begin n_bad++; $display("FAIL high_clamp_thick: cols 2040..2047 got %b required 11110000", hi2); end
        n_cmp++; if (hi0 !== 8'h40) begin n_bad++; $display("FAIL high_point: cols 2040..2047 got %b required 01000000", hi0); end
        d = diff_maps(0) + diff_maps(1);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL high_elsewhere: %0d lit pixels required 0", d); end
    endtask

    task automatic test_overrun();
        int d;
        clear_map();
        set_line(0, 3, 60, 3);
        nf_px(H_TOT-5, 2);
        scan(H_TOT-4, 2, 2);
        px(0, 3);
        n_cmp++; if (bus0.overrun_out !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b required 1", bus0.overrun_out); end
        scan(1, 3, V_TOT-1);
        scan(0, 0, V_TOT-1);
        d = diff_maps(0) + diff_maps(1);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL overrun_blank: %0d lit pixels required 0", d); end
        n_cmp++; if (fall_v !== 4 || fall_h !== 0) begin n_bad++; $display("FAIL overrun_busy_fall: got row %0d col %0d required row 4 col 0", fall_v, fall_h); end
        n_cmp++; if (bus0.overrun_out !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b required 1", bus0.overrun_out); end
        nf_px(0, 0);
        n_cmp++; if (bus0.overrun_out !== 1'b0) begin n_bad++; $display("FAIL overrun_clear: got %b required 0", bus0.overrun_out); end
    endtask

    task automatic test_async_reset();
        int d;
        clear_map();
        set_line(0, 3, 60, 3);
        nf_px(H_TOT-5, 2);
        scan(H_TOT-4, 2, 2);
        for (int h = 0; h <= 2; h++) px(h, 3);
        n_cmp++; if (bus0.overrun_out !== 1'b1 || bus0.busy_out !== 1'b1) begin n_bad++; $display("FAIL arst_pre_flags: got busy %b overrun %b required 1 1", bus0.busy_out, bus0.overrun_out); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus0.busy_out !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b required 0", bus0.busy_out); end
        n_cmp++; if (bus0.overrun_out !== 1'b0) begin n_bad++; $display("FAIL arst_overrun: got %b required 0", bus0.overrun_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;

        clear_map();
        set_line(0, 5, 127, 6);
        nf_px(0, 0);
        scan(1, 0, 4);
        for (int h = 0; h <= 10; h++) px(h, 5);
        n_cmp++; if (bus0.color_out !== COL) begin n_bad++; $display("FAIL arst_pre_color: got %h required %h", bus0.color_out, COL); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus0.color_out !== 24'h0) begin n_bad++; $display("FAIL arst_color: got %h required 000000", bus0.color_out); end
        n_cmp++; if (bus0.busy_out !== 1'b0) begin n_bad++; $display("FAIL arst_busy2: got %b required 0", bus0.busy_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;

        clear_map();
        scan(0, 0, V_TOT-1);
        d = diff_maps(0) + diff_maps(1);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL arst_no_draw: %0d lit pixels required 0", d); end
        n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL arst_idle_busy: got %b required 0", busy_seen); end

        clear_map();
        set_line(100, 10, 103, 20);
        nf_px(0, 0);
        for (int h = 1; h <= 5; h++) px(h, 0);
        set_line(10, 5, 20, 5);
        for (int h = 10; h <= 20; h++) exp0[5][h] = 1'b1;
        for (int h = 8; h <= 22; h++)  exp2[5][h] = 1'b1;
        nf_px(6, 0);
        scan(7, 0, V_TOT-1);
        d = diff_maps(0) + diff_maps(1);
        n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL restart_pixels: %0d wrong pixels required 0", d); end
        n_cmp++; if (fall_v !== 5 || fall_h !== 0) begin n_bad++; $display("FAIL restart_busy_fall: got row %0d col %0d required row 5 col 0", fall_v, fall_h); end
    endtask

    initial begin
        test_reset();
        test_horizontal(1'b1);
        test_horizontal(1'b0);
        test_steep();
        test_thick_clamp();
        test_overrun();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
